// File: rtl/data_reuse_pkg.sv
// -----------------------------------------------------------------------------
// data_reuse_pkg
// Shared definitions for the weight-stationary data-reuse engine:
//   - state_e        : engine FSM states
//   - DEFAULT_DATA_W : default RAM word width
//   - PERF_CNT_W     : width of the optional performance counters
//   - sat_inc()      : saturating increment for those counters
// -----------------------------------------------------------------------------
package data_reuse_pkg;

    localparam int DEFAULT_DATA_W = 128;
    localparam int PERF_CNT_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_WAIT_W,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/data_reuse_if.sv
// -----------------------------------------------------------------------------
// data_reuse_if
// Valid/ready pair stream from the data-reuse engine to the MAC array.
//   out_valid    : pair available            (master -> slave)
//   out_ready    : consumer accepts          (slave  -> master)
//   out_img      : image word                (master -> slave)
//   out_wgt      : weight word for out_img   (master -> slave)
//   out_last_img : last image word of the current weight
//   out_last     : final pair of the job
// Modports: master (engine side), slave (consumer side).
// -----------------------------------------------------------------------------
interface data_reuse_if
    import data_reuse_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) ();

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_img;
    logic [DATA_W-1:0] out_wgt;
    logic              out_last_img;
    logic              out_last;

    modport master (
        output out_valid, out_img, out_wgt, out_last_img, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_img, out_wgt, out_last_img, out_last,
        output out_ready
    );

endinterface

// File: rtl/data_reuse_skid_fifo.sv
// -----------------------------------------------------------------------------
// data_reuse_skid_fifo
// Synchronous FIFO (WIDTH x DEPTH, DEPTH a power of 2) that exposes its fill
// level so the producer can run a credit check before issuing reads.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write request and data (accepted when not full, or when a pop
//                happens in the same cycle)
//   pop        : read request (ignored when empty)
//   rdata      : head entry, valid whenever count != 0
//   count      : number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module data_reuse_skid_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);
    assign rdata   = mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count define validity,
    // so resetting the array would add reset fan-out for no behavioural gain.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_reuse_engine.sv
// -----------------------------------------------------------------------------
// data_reuse_engine
// Weight-stationary data-reuse engine. Each weight word is fetched once and
// paired with every word of the image tile; pairs leave through a small FIFO
// on a valid/ready stream.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle job start, ignored while busy
//   img_base/img_len    : image tile start address and length (words)
//   wgt_base/wgt_len    : weight start address and count (words)
//   img_rd_en/img_addr  : image RAM read port, img_rdata one cycle later
//   wgt_rd_en/wgt_addr  : weight RAM read port, wgt_rdata one cycle later
//   stream              : data_reuse_if.master pair stream
//   busy, done          : job in progress / one-cycle end-of-job pulse
// Optional feature (macro DATA_REUSE_PERF_EN): perf_img_reads, perf_wgt_reads,
// perf_stall_cycles saturating counters, cleared on an accepted start.
// -----------------------------------------------------------------------------
module data_reuse_engine
    import data_reuse_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int IMG_ADDR_W = 10,
    parameter int WGT_ADDR_W = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IMG_ADDR_W-1:0] img_base,
    input  logic [IMG_ADDR_W-1:0] img_len,
    input  logic [WGT_ADDR_W-1:0] wgt_base,
    input  logic [WGT_ADDR_W-1:0] wgt_len,
    output logic                  img_rd_en,
    output logic [IMG_ADDR_W-1:0] img_addr,
    input  logic [DATA_W-1:0]     img_rdata,
    output logic                  wgt_rd_en,
    output logic [WGT_ADDR_W-1:0] wgt_addr,
    input  logic [DATA_W-1:0]     wgt_rdata,
    output logic                  busy,
    output logic                  done,
    data_reuse_if.master          stream
`ifdef DATA_REUSE_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_img_reads,
    output logic [PERF_CNT_W-1:0] perf_wgt_reads,
    output logic [PERF_CNT_W-1:0] perf_stall_cycles
`endif
);

    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W  = 2 * DATA_W + 2;

    state_e state, state_next;

    logic [IMG_ADDR_W-1:0] img_base_r, img_len_r, img_idx;
    logic [WGT_ADDR_W-1:0] wgt_base_r, wgt_len_r, wgt_idx;
    logic [DATA_W-1:0]     wgt_reg;

    // Exactly one image read can be in flight (RAM latency is one cycle);
    // its tags travel alongside it so the FIFO entry is complete on return.
    logic inflight, infl_last_img, infl_last;

    logic               start_accept;
    logic               last_img_idx, last_wgt_idx;
    logic               credit_ok, pop, out_valid;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     occupancy;
    logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;

    assign start_accept = (state == ST_IDLE) && start;
    assign last_img_idx = (img_idx == img_len_r - 1'b1);
    assign last_wgt_idx = (wgt_idx == wgt_len_r - 1'b1);

    // Credit check counts the inflight read so the FIFO can never overflow,
    // even though that read lands a cycle after it is issued.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    assign credit_ok = (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

    assign img_rd_en = (state == ST_STREAM) && credit_ok;
    assign img_addr  = img_base_r + img_idx;
    assign wgt_rd_en = (state == ST_LOAD_W);
    assign wgt_addr  = wgt_base_r + wgt_idx;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && stream.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ((img_len == '0) || (wgt_len == '0)) ? ST_DONE : ST_LOAD_W;
                end
            end
            ST_LOAD_W: state_next = ST_WAIT_W;
            ST_WAIT_W: state_next = ST_STREAM;
            ST_STREAM: begin
                if (img_rd_en && last_img_idx) begin
                    state_next = last_wgt_idx ? ST_DRAIN : ST_LOAD_W;
                end
            end
            ST_DRAIN: begin
                // Look ahead by one pop so done lands right after the last handshake.
                if (!inflight &&
                    ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop))) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_base_r    <= '0;
            img_len_r     <= '0;
            wgt_base_r    <= '0;
            wgt_len_r     <= '0;
            img_idx       <= '0;
            wgt_idx       <= '0;
            wgt_reg       <= '0;
            inflight      <= 1'b0;
            infl_last_img <= 1'b0;
            infl_last     <= 1'b0;
        end else begin
            inflight      <= img_rd_en;
            infl_last_img <= last_img_idx;
            infl_last     <= last_img_idx && last_wgt_idx;
            if (start_accept) begin
                img_base_r <= img_base;
                img_len_r  <= img_len;
                wgt_base_r <= wgt_base;
                wgt_len_r  <= wgt_len;
                img_idx    <= '0;
                wgt_idx    <= '0;
            end
            if (state == ST_WAIT_W) begin
                wgt_reg <= wgt_rdata;
            end
            if (img_rd_en) begin
                if (last_img_idx) begin
                    img_idx <= '0;
                    wgt_idx <= wgt_idx + 1'b1;
                end else begin
                    img_idx <= img_idx + 1'b1;
                end
            end
        end
    end

    // The previous weight's last image read returns during LOAD_W, before
    // wgt_reg is overwritten in WAIT_W, so it is tagged with the right weight.
    assign fifo_wdata = {img_rdata, wgt_reg, infl_last_img, infl_last};

    data_reuse_skid_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    // Data is forced to zero when no pair is presented, hiding stale FIFO storage.
    assign stream.out_valid    = out_valid;
    assign stream.out_img      = out_valid ? fifo_rdata[ENTRY_W-1 -: DATA_W] : '0;
    assign stream.out_wgt      = out_valid ? fifo_rdata[DATA_W+1 -: DATA_W]  : '0;
    assign stream.out_last_img = out_valid && fifo_rdata[1];
    assign stream.out_last     = out_valid && fifo_rdata[0];

`ifdef DATA_REUSE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_img_reads    <= '0;
            perf_wgt_reads    <= '0;
            perf_stall_cycles <= '0;
        end else if (start_accept) begin
            perf_img_reads    <= '0;
            perf_wgt_reads    <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (img_rd_en)                      perf_img_reads    <= sat_inc(perf_img_reads);
            if (wgt_rd_en)                      perf_wgt_reads    <= sat_inc(perf_wgt_reads);
            if (out_valid && !stream.out_ready) perf_stall_cycles <= sat_inc(perf_stall_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_data_reuse_engine.sv
// -----------------------------------------------------------------------------
// tb_data_reuse_engine
// Self-checking bench for data_reuse_engine. Contains RAM models, a job-level
// expectation model (pair / address queues built from the job parameters),
// a negedge monitor comparing the DUT against it, and directed jobs.
// Honours DATA_REUSE_PERF_EN to connect and check the perf counters.
// -----------------------------------------------------------------------------
module tb_data_reuse_engine;
    import data_reuse_pkg::*;

    localparam int DATA_W = 128;
    localparam int IAW    = 10;
    localparam int WAW    = 8;

    typedef struct packed {
        logic [DATA_W-1:0] img;
        logic [DATA_W-1:0] wgt;
        logic              li;
        logic              l;
    } pair_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [IAW-1:0]    img_base = '0, img_len = '0;
    logic [WAW-1:0]    wgt_base = '0, wgt_len = '0;
    logic              img_rd_en, wgt_rd_en, busy, done;
    logic [IAW-1:0]    img_addr;
    logic [WAW-1:0]    wgt_addr;
    logic [DATA_W-1:0] img_rdata = '0, wgt_rdata = '0;
`ifdef DATA_REUSE_PERF_EN
    logic [31:0]       perf_img_reads, perf_wgt_reads, perf_stall_cycles;
`endif

    data_reuse_if #(.DATA_W(DATA_W)) out_if ();

    data_reuse_engine #(
        .DATA_W(DATA_W), .IMG_ADDR_W(IAW), .WGT_ADDR_W(WAW), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .img_base(img_base), .img_len(img_len),
        .wgt_base(wgt_base), .wgt_len(wgt_len),
        .img_rd_en(img_rd_en), .img_addr(img_addr), .img_rdata(img_rdata),
        .wgt_rd_en(wgt_rd_en), .wgt_addr(wgt_addr), .wgt_rdata(wgt_rdata),
        .busy(busy), .done(done), .stream(out_if)
`ifdef DATA_REUSE_PERF_EN
        , .perf_img_reads(perf_img_reads), .perf_wgt_reads(perf_wgt_reads),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // RAM contents are a pure function of address.
    function automatic logic [DATA_W-1:0] img_word(input logic [IAW-1:0] a);
        return {48'hA1A1_A1A1_A1A1, 64'h0, 6'h0, a};
    endfunction
    function automatic logic [DATA_W-1:0] wgt_word(input logic [WAW-1:0] a);
        return {48'hB2B2_B2B2_B2B2, 72'h0, a};
    endfunction

    always @(posedge clk) begin
        if (img_rd_en) img_rdata <= img_word(img_addr);
        if (wgt_rd_en) wgt_rdata <= wgt_word(wgt_addr);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [263:0] act, input logic [263:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model state ----------------
    pair_t          exp_q[$];
    logic [IAW-1:0] exp_iaddr[$];
    logic [WAW-1:0] exp_waddr[$];
    int             img_reads, wgt_reads, pair_idx, stall_cnt, done_cnt, last_hs, ncyc;
    logic [31:0]    li_mask, l_mask;
    logic [IAW-1:0] addr_log [4];
    logic [DATA_W-1:0] first_img, first_wgt;
    bit             prev_stall;
    logic [2*DATA_W+1:0] held;
    pair_t          mon_e;

    // ---------------- ready driver ----------------
    bit          ready_mode = 1'b0;
    int          pcnt = 0;
    logic [3:0]  pat = 4'b1001;   // 1,0,0,1
    initial begin
        out_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                out_if.out_ready = pat[3 - (pcnt % 4)];
                pcnt++;
            end else begin
                out_if.out_ready = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        ncyc++;
        if (img_rd_en) begin
            if (img_reads < 4) addr_log[img_reads] = img_addr;
            img_reads++;
            if (exp_iaddr.size() == 0) check("img_rd_unexpected", 1, 0);
            else check("img_addr", img_addr, exp_iaddr.pop_front());
        end
        if (wgt_rd_en) begin
            wgt_reads++;
            if (exp_waddr.size() == 0) check("wgt_rd_unexpected", 1, 0);
            else check("wgt_addr", wgt_addr, exp_waddr.pop_front());
        end
        if (out_if.out_valid && prev_stall)
            check("stall_hold", {out_if.out_img, out_if.out_wgt, out_if.out_last_img, out_if.out_last}, held);
        if (out_if.out_valid && out_if.out_ready) begin
            if (exp_q.size() == 0) begin
                check("pair_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pair_img", out_if.out_img, mon_e.img);
                check("pair_wgt", out_if.out_wgt, mon_e.wgt);
                check("pair_flags", {out_if.out_last_img, out_if.out_last}, {mon_e.li, mon_e.l});
            end
            if (pair_idx == 0) begin
                first_img = out_if.out_img;
                first_wgt = out_if.out_wgt;
            end
            if (pair_idx < 32) begin
                li_mask[pair_idx] = out_if.out_last_img;
                l_mask[pair_idx]  = out_if.out_last;
            end
            pair_idx++;
            last_hs = ncyc;
        end
        if (out_if.out_valid && !out_if.out_ready) stall_cnt++;
        prev_stall = out_if.out_valid && !out_if.out_ready;
        held = {out_if.out_img, out_if.out_wgt, out_if.out_last_img, out_if.out_last};
        if (done) begin
            done_cnt++;
            if (pair_idx > 0) check("done_after_last_hs", ncyc, last_hs + 1);
        end
    end

    // Build the expectation for a whole job from its parameters.
    task automatic setup_job(input int ib, input int il, input int wb, input int wl);
        exp_q.delete();
        exp_iaddr.delete();
        exp_waddr.delete();
        for (int w = 0; w < wl; w++) begin
            exp_waddr.push_back(WAW'(wb + w));
            for (int i = 0; i < il; i++) begin
                exp_iaddr.push_back(IAW'(ib + i));
                exp_q.push_back({img_word(IAW'(ib + i)), wgt_word(WAW'(wb + w)),
                                 1'(i == il - 1), 1'((i == il - 1) && (w == wl - 1))});
            end
        end
        img_reads = 0; wgt_reads = 0; pair_idx = 0; stall_cnt = 0; done_cnt = 0;
        li_mask = '0; l_mask = '0; pcnt = 0;
    endtask

    task automatic pulse_start(input int ib, input int il, input int wb, input int wl);
        @(negedge clk);
        img_base = IAW'(ib); img_len = IAW'(il);
        wgt_base = WAW'(wb); wgt_len = WAW'(wl);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_job(input int ib, input int il, input int wb, input int wl,
                           input bit mode, input bit timing, input bit glitch);
        bit got;
        setup_job(ib, il, wb, wl);
        ready_mode = mode;
        pulse_start(ib, il, wb, wl);      // now in cycle T+1
        if (timing) begin
            check("t1_busy", busy, 1);
            check("t1_wgt_rd_en", wgt_rd_en, 1);
            @(negedge clk);
            check("t2_no_rd", {wgt_rd_en, img_rd_en}, 2'b00);
            @(negedge clk);
            check("t3_img_rd_en", img_rd_en, 1);
            @(negedge clk);
            check("t4_no_valid", out_if.out_valid, 0);
            @(negedge clk);
            check("t5_valid", out_if.out_valid, 1);
        end
        got = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (glitch && c == 2) begin start = 1'b1; img_base = IAW'(999); end
            if (glitch && c == 3) start = 1'b0;
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
        end
        check("done_seen", got, 1);
        repeat (4) @(negedge clk);
        ready_mode = 1'b0;
        check("pair_count", pair_idx, il * wl);
        check("img_read_count", img_reads, il * wl);
        check("wgt_read_count", wgt_reads, wl);
        check("pairs_left", exp_q.size(), 0);
        check("done_pulses", done_cnt, 1);
        check("idle_after_job", busy, 0);
`ifdef DATA_REUSE_PERF_EN
        check("perf_img_reads", perf_img_reads, il * wl);
        check("perf_wgt_reads", perf_wgt_reads, wl);
        check("perf_stall_cycles", perf_stall_cycles, stall_cnt);
`endif
    endtask

    initial begin
        bit seen;
        // Reset state
        repeat (2) @(negedge clk);
        check("reset_ctrl", {img_rd_en, wgt_rd_en, img_addr, wgt_addr, out_if.out_valid,
                             out_if.out_last_img, out_if.out_last, busy, done}, 0);
        check("reset_data", {out_if.out_img, out_if.out_wgt}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic job with latency checks; pin the model with literals.
        run_job(10, 4, 5, 2, 1'b0, 1'b1, 1'b0);
        check("lit_last_img_mask", li_mask, 32'h88);
        check("lit_last_mask", l_mask, 32'h80);
        check("lit_first_img", first_img, 128'hA1A1A1A1A1A1_0000000000000000_000A);
        check("lit_first_wgt", first_wgt, 128'hB2B2B2B2B2B2_000000000000000000_05);

        // Backpressure 1,0,0,1
        run_job(10, 4, 5, 2, 1'b1, 1'b0, 1'b0);
        check("stalls_happened", stall_cnt > 0, 1);

        // Address wrap on both RAMs
        run_job(1022, 4, 255, 2, 1'b0, 1'b0, 1'b0);
        check("lit_wrap_addrs", {addr_log[0], addr_log[1], addr_log[2], addr_log[3]},
              {10'd1022, 10'd1023, 10'd0, 10'd1});

        // Zero image length
        setup_job(0, 0, 0, 0);
        pulse_start(3, 0, 4, 2);
        check("zero_done_t1", {done, busy}, 2'b11);
        @(negedge clk);
        check("zero_done_t2", {done, busy}, 2'b00);
        repeat (3) @(negedge clk);
        check("zero_no_reads", img_reads + wgt_reads, 0);
        check("zero_done_pulses", done_cnt, 1);

        // Zero weight length
        setup_job(0, 0, 0, 0);
        pulse_start(3, 4, 4, 0);
        check("zero_w_done_t1", done, 1);
        repeat (3) @(negedge clk);
        check("zero_w_no_reads", img_reads + wgt_reads, 0);

        // Start while busy is ignored
        run_job(100, 3, 7, 3, 1'b0, 1'b0, 1'b1);

        // Reset during STREAM
        setup_job(20, 8, 9, 2);
        pulse_start(20, 8, 9, 2);
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (img_reads >= 2) begin seen = 1'b1; break; end
        end
        check("reset_job_streaming", seen, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midreset_ctrl", {img_rd_en, wgt_rd_en, img_addr, wgt_addr, out_if.out_valid,
                                out_if.out_last_img, out_if.out_last, busy, done}, 0);
        check("midreset_data", {out_if.out_img, out_if.out_wgt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_no_done", done_cnt, 0);
        run_job(20, 8, 9, 2, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
